// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants.
// Used by this transmitter and by the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with power-of-two depth and an occupancy count.
// Pushes are dropped while full, even when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ext.sv
// UART transmitter with transmit FIFO, configurable data bits, parity and stop bits.
// Frames are sent back-to-back with no idle gap while the FIFO holds words.
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned UART_BPS   = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned BaudW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_ext: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_ext: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_ext: FIFO_DEPTH must be a power of two, at least 2");
  end

  uart_state_e           state_q;
  logic [BaudW-1:0]      baud_cnt_q;
  logic [3:0]            bit_cnt_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  parity_q;
  logic                  txd_q;

  logic                  fifo_full, fifo_empty, pop, bit_end, last_stop, head_parity;
  logic [DATA_BITS-1:0]  fifo_head;

  uart_sync_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end     = (baud_cnt_q == BaudW'(BAUD_CNT_MAX - 1));
  assign last_stop   = (state_q == StStop) && bit_end && (bit_cnt_q == 4'(STOP_BITS - 1));
  // A word leaves the FIFO only when a new frame starts, from idle or straight after a stop bit.
  assign pop         = !fifo_empty && ((state_q == StIdle) || last_stop);
  assign head_parity = (^fifo_head) ^ (PARITY == PAR_ODD);

  assign tx_ready = !fifo_full;
  assign uart_txd = txd_q;
  assign tx_busy  = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      if (state_q != StIdle) begin
        baud_cnt_q <= bit_end ? '0 : baud_cnt_q + BaudW'(1);
      end
      unique case (state_q)
        StIdle: begin
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (pop) begin
            state_q  <= StStart;
            txd_q    <= 1'b0;
            shift_q  <= fifo_head;
            parity_q <= head_parity;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q   <= StData;
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
              if (PARITY != PAR_NONE) begin
                state_q <= StParity;
                txd_q   <= parity_q;
              end else begin
                state_q <= StStop;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_q <= StStop;
            txd_q   <= 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            if (last_stop) begin
              bit_cnt_q <= '0;
              if (pop) begin
                state_q  <= StStart;
                txd_q    <= 1'b0;
                shift_q  <= fifo_head;
                parity_q <= head_parity;
              end else begin
                state_q <= StIdle;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Bench for uart_tx_ext: six instances covering 8N1, 8E1, 8O1, 8N2, a depth-4 FIFO and 7E1,
// all at 10 clocks per bit.
module tb_uart_tx_ext;
  import uart_pkg::*;

  localparam int unsigned CF  = 1_000_000;
  localparam int unsigned BPS = 100_000;
  localparam int IxN1 = 0, IxE1 = 1, IxO1 = 2, IxN2 = 3, IxF4 = 4, IxE7 = 5;

  logic       clk;
  logic [5:0] rst_v, valid_v, txd_v, busy_v, ready_v;
  logic [7:0] data_a [6];
  logic [4:0] cnt0, cnt1, cnt2, cnt3, cnt5;
  logic [2:0] cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_ext #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(PAR_NONE),
                .STOP_BITS(1), .FIFO_DEPTH(16)) u_n1 (
    .clk(clk), .rst(rst_v[IxN1]), .tx_valid(valid_v[IxN1]), .tx_data(data_a[IxN1]),
    .tx_ready(ready_v[IxN1]), .uart_txd(txd_v[IxN1]), .tx_busy(busy_v[IxN1]), .fifo_count(cnt0));
  uart_tx_ext #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(PAR_EVEN),
                .STOP_BITS(1), .FIFO_DEPTH(16)) u_e1 (
    .clk(clk), .rst(rst_v[IxE1]), .tx_valid(valid_v[IxE1]), .tx_data(data_a[IxE1]),
    .tx_ready(ready_v[IxE1]), .uart_txd(txd_v[IxE1]), .tx_busy(busy_v[IxE1]), .fifo_count(cnt1));
  uart_tx_ext #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(PAR_ODD),
                .STOP_BITS(1), .FIFO_DEPTH(16)) u_o1 (
    .clk(clk), .rst(rst_v[IxO1]), .tx_valid(valid_v[IxO1]), .tx_data(data_a[IxO1]),
    .tx_ready(ready_v[IxO1]), .uart_txd(txd_v[IxO1]), .tx_busy(busy_v[IxO1]), .fifo_count(cnt2));
  uart_tx_ext #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(PAR_NONE),
                .STOP_BITS(2), .FIFO_DEPTH(16)) u_n2 (
    .clk(clk), .rst(rst_v[IxN2]), .tx_valid(valid_v[IxN2]), .tx_data(data_a[IxN2]),
    .tx_ready(ready_v[IxN2]), .uart_txd(txd_v[IxN2]), .tx_busy(busy_v[IxN2]), .fifo_count(cnt3));
  uart_tx_ext #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(PAR_NONE),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u_f4 (
    .clk(clk), .rst(rst_v[IxF4]), .tx_valid(valid_v[IxF4]), .tx_data(data_a[IxF4]),
    .tx_ready(ready_v[IxF4]), .uart_txd(txd_v[IxF4]), .tx_busy(busy_v[IxF4]), .fifo_count(cnt4));
  uart_tx_ext #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(7), .PARITY(PAR_EVEN),
                .STOP_BITS(1), .FIFO_DEPTH(16)) u_e7 (
    .clk(clk), .rst(rst_v[IxE7]), .tx_valid(valid_v[IxE7]), .tx_data(data_a[IxE7][6:0]),
    .tx_ready(ready_v[IxE7]), .uart_txd(txd_v[IxE7]), .tx_busy(busy_v[IxE7]), .fifo_count(cnt5));

  function automatic logic [4:0] cnt_of(input int idx);
    case (idx)
      0:       return cnt0;
      1:       return cnt1;
      2:       return cnt2;
      3:       return cnt3;
      4:       return {2'b00, cnt4};
      default: return cnt5;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference framing: start 0, data LSB first, optional parity, stop ones; index 0 = first bit.
  function automatic logic [0:11] frame_bits(input logic [7:0] w, input int nd, input int par,
                                             input int ns);
    logic [0:11] f;
    logic        p;
    int          k;
    f = '0;
    p = 1'b0;
    k = 1;
    for (int i = 0; i < nd; i++) begin
      f[k] = w[i];
      p    = p ^ w[i];
      k++;
    end
    if (par != 0) begin
      f[k] = (par == 1) ? ~p : p;
      k++;
    end
    for (int i = 0; i < ns; i++) begin
      f[k] = 1'b1;
      k++;
    end
    return f;
  endfunction

  typedef struct {
    int          idx;
    logic [7:0]  word;
    logic [0:11] bits;
    int          nbits;
  } vec_t;

  vec_t vecs [10];

  // Push one word into an idle instance and check every line cycle of the resulting frame.
  task automatic run_vector(input int vn, input vec_t v);
    logic seen;
    int   busy_cycles;
    @(negedge clk);
    data_a[v.idx]  = v.word;
    valid_v[v.idx] = 1'b1;
    @(negedge clk);
    valid_v[v.idx] = 1'b0;
    check($sformatf("vec%0d accepted_not_started", vn), {busy_v[v.idx], 3'b0, cnt_of(v.idx)},
          {1'b0, 3'b0, 5'd1});
    busy_cycles = 0;
    for (int b = 0; b < v.nbits; b++) begin
      seen = v.bits[b];
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (txd_v[v.idx] !== v.bits[b] && seen === v.bits[b]) seen = txd_v[v.idx];
        if (busy_v[v.idx] === 1'b1) busy_cycles++;
      end
      check($sformatf("vec%0d line_bit%0d", vn, b), seen, v.bits[b]);
    end
    check($sformatf("vec%0d busy_clocks", vn), busy_cycles, v.nbits * 10);
    @(negedge clk);
    check($sformatf("vec%0d idle_after", vn), {busy_v[v.idx], txd_v[v.idx]}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v   = '1;
    valid_v = '0;
    for (int i = 0; i < 6; i++) data_a[i] = '0;

    vecs[0] = '{IxN1, 8'h55, 12'b0101_0101_0100, 10};
    vecs[1] = '{IxN1, 8'h00, 12'b0000_0000_0100, 10};
    vecs[2] = '{IxN1, 8'hF0, 12'b0000_0111_1100, 10};
    vecs[3] = '{IxE1, 8'h07, 12'b0111_0000_0110, 11};
    vecs[4] = '{IxO1, 8'h07, 12'b0111_0000_0010, 11};
    vecs[5] = '{IxE1, 8'h00, 12'b0000_0000_0010, 11};
    vecs[6] = '{IxO1, 8'h00, 12'b0000_0000_0110, 11};
    vecs[7] = '{IxN2, 8'hA5, 12'b0101_0010_1110, 11};
    vecs[8] = '{IxE7, 8'h7F, 12'b0111_1111_1100, 10};
    vecs[9] = '{IxE7, 8'h01, 12'b0100_0000_1100, 10};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("reset inst%0d txd_busy_ready", i), {txd_v[i], busy_v[i], ready_v[i]},
            3'b101);
      check($sformatf("reset inst%0d fifo_count", i), cnt_of(i), 0);
    end
    rst_v = '0;
    @(negedge clk);
    check("ready_after_release", ready_v, 6'h3F);

    for (int n = 0; n < 10; n++) run_vector(n, vecs[n]);

    // 8N2 back-to-back: three contiguous 110-clock frames.
    begin
      logic [7:0]  w2 [3];
      logic [0:32] rx2;
      logic [0:11] e2;
      logic        drop2;
      w2 = '{8'hA5, 8'h3C, 8'hFF};
      rx2 = '0;
      drop2 = 1'b0;
      @(negedge clk);
      fork
        begin
          data_a[IxN2] = w2[0]; valid_v[IxN2] = 1'b1;
          @(negedge clk); data_a[IxN2] = w2[1];
          @(negedge clk); data_a[IxN2] = w2[2];
          @(negedge clk); valid_v[IxN2] = 1'b0;
        end
        begin
          repeat (2) @(negedge clk);
          for (int i = 0; i < 330; i++) begin
            if (i % 10 == 5) rx2[i/10] = txd_v[IxN2];
            if (busy_v[IxN2] !== 1'b1) drop2 = 1'b1;
            @(negedge clk);
          end
          check("n2 busy_never_drops", drop2, 1'b0);
          check("n2 idle_after_3_frames", {busy_v[IxN2], txd_v[IxN2]}, 2'b01);
        end
      join
      for (int f = 0; f < 3; f++) begin
        e2 = frame_bits(w2[f], 8, 0, 2);
        check($sformatf("n2 frame%0d", f), 32'(rx2[f*11 +: 11]), 32'(e2[0:10]));
      end
    end

    // Depth-4 FIFO with tx_valid held high for six words.
    begin
      logic [7:0]  w4 [6];
      logic [0:59] rx4;
      logic [0:11] e4;
      logic        drop4;
      w4 = '{8'h11, 8'h22, 8'h93, 8'hC4, 8'h5A, 8'hE6};
      rx4 = '0;
      drop4 = 1'b0;
      @(negedge clk);
      fork
        begin : p_push
          for (int k = 0; k < 6; k++) begin
            int guard;
            guard = 0;
            data_a[IxF4]  = w4[k];
            valid_v[IxF4] = 1'b1;
            while (ready_v[IxF4] !== 1'b1 && guard < 1000) begin
              @(negedge clk);
              guard++;
            end
            check($sformatf("f4 push%0d_within_bound", k), guard < 1000, 1'b1);
            @(negedge clk);
            if (k == 4) begin
              check("f4 count_full", cnt_of(IxF4), 4);
              check("f4 ready_low_when_full", ready_v[IxF4], 1'b0);
            end
          end
          valid_v[IxF4] = 1'b0;
        end
        begin : p_rx
          @(negedge clk);
          check("f4 not_started_after_first_push", busy_v[IxF4], 1'b0);
          @(negedge clk);
          check("f4 first_word_popped", {busy_v[IxF4], txd_v[IxF4]}, 2'b10);
          for (int i = 0; i < 600; i++) begin
            if (i % 10 == 5) rx4[i/10] = txd_v[IxF4];
            if (busy_v[IxF4] !== 1'b1) drop4 = 1'b1;
            @(negedge clk);
          end
          check("f4 busy_never_drops", drop4, 1'b0);
          check("f4 idle_after_6_frames", {busy_v[IxF4], txd_v[IxF4], cnt_of(IxF4)},
                {2'b01, 5'd0});
        end
      join
      for (int f = 0; f < 6; f++) begin
        e4 = frame_bits(w4[f], 8, 0, 1);
        check($sformatf("f4 frame%0d", f), 32'(rx4[f*10 +: 10]), 32'(e4[0:9]));
      end
    end

    // Reset in the middle of a data bit with three words still queued.
    begin
      logic idle_ok;
      @(negedge clk);
      data_a[IxN1] = 8'h81; valid_v[IxN1] = 1'b1;
      @(negedge clk); data_a[IxN1] = 8'h42;
      @(negedge clk); data_a[IxN1] = 8'h24;
      @(negedge clk); data_a[IxN1] = 8'h18;
      @(negedge clk); valid_v[IxN1] = 1'b0;
      repeat (33) @(negedge clk);
      check("rst pre count_3_busy", {busy_v[IxN1], 3'b0, cnt_of(IxN1)}, {1'b1, 3'b0, 5'd3});
      #2;
      rst_v[IxN1] = 1'b1;
      #1;
      check("rst async txd_busy", {txd_v[IxN1], busy_v[IxN1]}, 2'b10);
      check("rst async fifo_count", cnt_of(IxN1), 0);
      repeat (2) @(negedge clk);
      rst_v[IxN1] = 1'b0;
      @(negedge clk);
      check("rst ready_after_release", ready_v[IxN1], 1'b1);
      idle_ok = 1'b1;
      for (int i = 0; i < 200; i++) begin
        if (txd_v[IxN1] !== 1'b1 || busy_v[IxN1] !== 1'b0 || cnt_of(IxN1) !== 5'd0)
          idle_ok = 1'b0;
        @(negedge clk);
      end
      check("rst line_stays_idle", idle_ok, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ext.md
UART_TX_EXT -- requirements
Module: uart_tx_ext

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, line baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO depth; power of two, at least 2.
REQ-007 SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-009 SHALL have port tx_valid, input, 1, the producer offers tx_data.
REQ-010 SHALL have port tx_data, input, DATA_BITS, the word to transmit.
REQ-011 SHALL have port tx_ready, output, 1, the FIFO can accept a word.
REQ-012 SHALL have port uart_txd, output, 1, serial line; registered, idle high.
REQ-013 SHALL have port tx_busy, output, 1, a frame is in progress.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, number of words held in the FIFO.

Function
REQ-015 SHALL define BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division); every line bit SHALL last exactly BAUD_CNT_MAX clocks, with the baud counter running 0..BAUD_CNT_MAX-1.
REQ-016 SHALL accept a word on a rising edge where tx_valid and tx_ready are both high; tx_ready SHALL equal !full, decoded from registered state only.
REQ-017 SHALL write nothing when the FIFO is full, including on a cycle that also pops.
REQ-018 SHALL, on a simultaneous push and pop when not full, leave fifo_count unchanged.
REQ-019 SHALL use states IDLE, START, DATA, PARITY and STOP.
REQ-020 SHALL move IDLE->START on the edge after the FIFO becomes non-empty, pop the head word on that same edge, and drive uart_txd=0 from that edge; a word accepted at edge E into an empty, idle block SHALL start its start bit at edge E+1.
REQ-021 SHALL transmit data LSB first in DATA state, DATA_BITS bits in total.
REQ-022 SHALL enter PARITY only when PARITY!=0; the parity bit SHALL be the XOR of the data bits for even mode and its inverse for odd mode.
REQ-023 SHALL hold uart_txd=1 in STOP for STOP_BITS bit periods.
REQ-024 SHALL, on the last STOP cycle, go directly to START if the FIFO is non-empty, leaving zero idle clocks between frames; otherwise it SHALL go to IDLE.
REQ-025 SHALL give a total frame length of (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BAUD_CNT_MAX clocks.
REQ-026 SHALL drive tx_busy=1 exactly when the state is not IDLE.
REQ-027 SHALL hold the baud counter and the bit counter at 0 in IDLE.
REQ-028 SHALL wrap the FIFO pointers modulo FIFO_DEPTH; full SHALL mean fifo_count==FIFO_DEPTH and empty SHALL mean fifo_count==0.
REQ-029 SHALL capture the frame word into a shift register at pop; later FIFO writes SHALL NOT affect the frame in flight.

Reset
REQ-030 SHALL, on rst assertion, immediately and asynchronously force uart_txd=1, tx_busy=0, fifo_count=0, state IDLE, both counters 0 and both FIFO pointers 0.
REQ-031 SHALL, on reset mid-frame, abandon the frame and discard all FIFO contents; no partial frame SHALL resume after release.
REQ-032 SHALL drive tx_ready=1 from the first clock after rst deasserts.

Structure
REQ-033 SHALL place the state encodings and the PARITY mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2) in shared package uart_pkg, for reuse by the matching receiver.
REQ-034 SHALL implement the FIFO as sub-module uart_sync_fifo, parametrised by width and depth, with push, pop, full, empty and count.
REQ-035 SHALL check the parameter legality of REQ-003, REQ-005 and REQ-006 at elaboration and fail with an error when any is violated.

Verification (CLK_FREQ=1_000_000, UART_BPS=100_000, i.e. 10 clocks/bit)
REQ-036 SHALL test 8N1 with 0x55: uart_txd = 0,1,0,1,0,1,0,1,0,1 at 10 clocks each; tx_busy high for 100 clocks.
REQ-037 SHALL test 8E1 with 0x07 (parity bit 1) and 8O1 with 0x07 (parity bit 0); frame 110 clocks.
REQ-038 SHALL test 8N2 with 0xA5, 0x3C, 0xFF pushed back-to-back: three contiguous 110-clock frames, no idle gap, tx_busy never drops between frames.
REQ-039 SHALL test FIFO_DEPTH=4 with tx_valid held high for 6 words while idle: first word popped at once, tx_ready low once fifo_count=4, no word lost or duplicated.
REQ-040 SHALL test rst asserted mid-data-bit with 3 words queued: uart_txd=1 and fifo_count=0 in the same cycle, and the line stays idle after release.
REQ-041 SHALL test DATA_BITS=7, PARITY=2 with 0x7F: 7 ones, parity bit 1, frame 100 clocks.
